// File: rtl/regfile_mp.sv
// Multi-port register file with ALU and memory write ports, a flags register,
// same-cycle write forwarding on registered read ports, and a pending scoreboard.
module regfile_mp #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 3,
  parameter int                 RD_PORTS  = 2,
  parameter int                 PC_IDX    = 3,
  parameter logic [DATA_W-1:0]  FLAGS_RST = '0,
  localparam int                NUM_REGS  = 2 ** ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]            rd_pc,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  input  logic                         alu_d_wr,
  input  logic [ADDR_W-1:0]            alu_d_adr,
  input  logic [DATA_W-1:0]            alu_r,
  input  logic                         mem_d_wr,
  input  logic [ADDR_W-1:0]            mem_d_adr,
  input  logic [DATA_W-1:0]            mem_r,
  input  logic                         alu_sf_wr,
  input  logic [DATA_W-1:0]            alu_sf,
  input  logic                         rmw_sf_w,
  input  logic [DATA_W-1:0]            rmw_sf,
  input  logic                         iss_valid,
  input  logic [ADDR_W-1:0]            iss_adr,
  output logic                         conflict_sf,
  output logic                         conflict_d,
  output logic [NUM_REGS-1:0]          pending,
  output logic [DATA_W-1:0]            flags
);

  localparam logic [ADDR_W-1:0] PC_ADR = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0]          regs [NUM_REGS];
  logic [RD_PORTS*DATA_W-1:0] rd_next;
  logic [NUM_REGS-1:0]        pending_next;
  logic                       alu_acc;
  logic                       mem_acc;

  // A flags clash forces the ALU op to replay, so its register write is dropped too.
  assign conflict_sf = alu_sf_wr & rmw_sf_w;
  assign conflict_d  = alu_d_wr & mem_d_wr & (alu_d_adr == mem_d_adr) & ~conflict_sf;
  assign alu_acc     = alu_d_wr & ~conflict_sf & ~conflict_d;
  assign mem_acc     = mem_d_wr;

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    rd_next = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      if (rd_addr[k*ADDR_W +: ADDR_W] == PC_ADR)
        rd_next[k*DATA_W +: DATA_W] = rd_pc;
      else if (mem_acc && rd_addr[k*ADDR_W +: ADDR_W] == mem_d_adr)
        rd_next[k*DATA_W +: DATA_W] = mem_r;
      else if (alu_acc && rd_addr[k*ADDR_W +: ADDR_W] == alu_d_adr)
        rd_next[k*DATA_W +: DATA_W] = alu_r;
      else
        rd_next[k*DATA_W +: DATA_W] = regs[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

  // Clears are applied before the set so an issue wins over a same-index write.
  always_comb begin
    pending_next = pending;
    if (mem_acc)   pending_next[mem_d_adr] = 1'b0;
    if (alu_acc)   pending_next[alu_d_adr] = 1'b0;
    if (iss_valid) pending_next[iss_adr]   = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is flop-based and must read back 0 after reset, so it is reset explicitly.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (mem_acc) regs[mem_d_adr] <= mem_r;
      if (alu_acc) regs[alu_d_adr] <= alu_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      pending <= '0;
      flags   <= FLAGS_RST;
    end else begin
      rd_data <= rd_next;
      pending <= pending_next;
      if (rmw_sf_w)       flags <= rmw_sf;
      else if (alu_sf_wr) flags <= alu_sf;
    end
  end

endmodule
